trail_manager: RTL and testbench
================================

# trail_manager

Generates and ages the player's motion-trail particles that the VGA pixel renderer draws behind Steve. Once per frame, during vertical blanking, it sweeps a 41-entry particle table, drifting and fading each live particle, then emits a new particle at the player's current position. It drives the `trail_x` / `trail_y` / `trail_life` arrays consumed by the screen-picture block and is sequenced by the game mode.

## Interface

Parameters:
- `TRAIL_N`, 41, number of particle slots (must match renderer array depth)
- `LIFE_MAX`, 10, life assigned to a newly emitted particle (4-bit)
- `EMIT_DIV`, 1, emit one particle every `EMIT_DIV` active frames
- `DECAY_DIV`, 2, decrement life every `DECAY_DIV` frames
- `DRIFT`, 4, pixels each live particle moves left per swept frame
- `PLAYER_X`, 160, player left edge
- `PLAYER_SIZE`, 40, player sprite size

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  synchronous, active-low reset
- `frame_tick`  in  1  single-cycle pulse at the start of vertical blanking
- `gamemode`  in  2  00 start, 01 running, 10 paused, 11 game over
- `player_y`  in  9  player top edge
- `trail_x`  out  [TRAIL_N-1:0][9:0]  particle centre x
- `trail_y`  out  [TRAIL_N-1:0][8:0]  particle centre y
- `trail_life`  out  [TRAIL_N-1:0][3:0]  remaining life; 0 means the slot is empty
- `busy`  out  1  high while the sweep/emit sequence runs

## Operation

- The block has a four-state FSM: IDLE, SWEEP, EMIT, CLEAR.
- **IDLE:** waits for `frame_tick`.
  - `gamemode`=01 or 11 → SWEEP, with `idx`=0.
  - `gamemode`=00 → CLEAR, with `idx`=0.
  - `gamemode`=10 → stays in IDLE. The table, counters and `wr_ptr` are frozen.
- **SWEEP:** visits one slot per cycle, `idx` 0..TRAIL_N-1.
  - A slot with life 0 is left unchanged.
  - A slot with life > 0:
    - if `trail_x[idx]` < DRIFT, its life is set to 0;
    - otherwise `trail_x[idx]` -= DRIFT, and if `decay_cnt`==0, life -= 1.
  - After `idx`=TRAIL_N-1:
    - `gamemode`=01 (sampled at the last SWEEP cycle) and `emit_cnt`==0 → EMIT;
    - otherwise → IDLE.
- **EMIT:** writes one new particle at slot `wr_ptr`:
  - x = PLAYER_X − 2;
  - y = min(`player_y` + PLAYER_SIZE/2, 479), computed in 10 bits and then truncated to 9;
  - life = LIFE_MAX.
  - `wr_ptr` then increments, wrapping from TRAIL_N-1 to 0. The oldest slot is overwritten regardless of its remaining life.
  - Next state → IDLE.
- **Frame counters:** `decay_cnt` (0..DECAY_DIV-1) and `emit_cnt` (0..EMIT_DIV-1) increment modulo their divisor on the last SWEEP cycle of every sweep.
  - In game-over mode, particles keep drifting and fading but no new ones are emitted.
- **CLEAR:** visits one slot per cycle and sets x=0, y=0, life=0.
  - On its last cycle it resets `wr_ptr`, `decay_cnt` and `emit_cnt` to 0, then → IDLE.
- **Mode changes:** a `gamemode` change in the middle of a sequence does not abort it. Only the EMIT decision samples the mode late.
- **Renderer contract:** the renderer ignores entries with life 0, so stale x/y values in empty slots are harmless.

## Timing

- **Reset** (`rst_n`=0 at a rising edge), required values one cycle later:
  - all `trail_x`, `trail_y`, `trail_life` = 0;
  - `busy`=0;
  - FSM in IDLE;
  - `wr_ptr`, `decay_cnt`, `emit_cnt` = 0.
  - Reset asserted mid-sweep has the same effect.
- **Sequence timing**, with `frame_tick` sampled high in IDLE at cycle T:
  - SWEEP occupies cycles T+1..T+TRAIL_N; slot k is updated at the edge ending cycle T+1+k;
  - EMIT, if taken, occupies cycle T+TRAIL_N+1;
  - `busy`=1 from T+1 through the last SWEEP or EMIT cycle, and 0 in IDLE.
- **Worst-case length:** 42 cycles, which fits inside vertical blanking.
- **`frame_tick` while `busy`:** ignored, with no queuing.
- **Output timing:** outputs are registered and change only in SWEEP, EMIT and CLEAR cycles. The renderer sees a stable table during active video.

## Test plan

- **Reset and first emission:** after reset, pulse `frame_tick` with `gamemode`=01 and `player_y`=200.
  - `busy` is high for 42 cycles.
  - slot 0 = (158, 220, 10); all other slots have life 0; `wr_ptr`=1.
- **Decay and drift:** emit one particle, then run further frames in mode 10 → 01 with emission suppressed (EMIT_DIV=64).
  - The particle's x decreases by 4 per frame and its life decreases by 1 every 2nd frame.
  - Its life reaches 0 after the expected frame count.
- **Wrap-around:** 42 frames in mode 01.
  - Slot 0 is overwritten on frame 42 with life 10; `wr_ptr`=1.
- **Pause freeze:** run 5 frames in mode 01, then issue 3 `frame_tick`s in mode 10.
  - The table, `wr_ptr` and `busy` (=0) are unchanged.
- **Game over:** switch to mode 11.
  - Particles keep fading; no EMIT cycle occurs (`busy` lasts 41 cycles).
- **Clear, tick-during-busy and reset mid-sweep:**
  - mode 00 plus `frame_tick` → all life 0 and `wr_ptr`=0 after 41 cycles;
  - a second `frame_tick` at T+10 is ignored;
  - `rst_n`=0 at T+20 → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/trail_manager.sv
// Motion-trail particle table for the player sprite. Once per vertical blank it
// sweeps every slot (drift left, fade) and then spawns one particle at the player.
module trail_manager #(
  parameter int TRAIL_N     = 41,
  parameter int LIFE_MAX    = 10,
  parameter int EMIT_DIV    = 1,
  parameter int DECAY_DIV   = 2,
  parameter int DRIFT       = 4,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic [1:0]               gamemode,
  input  logic [8:0]               player_y,
  output logic [TRAIL_N-1:0][9:0]  trail_x,
  output logic [TRAIL_N-1:0][8:0]  trail_y,
  output logic [TRAIL_N-1:0][3:0]  trail_life,
  output logic                     busy
);

  localparam int IW = (TRAIL_N > 1) ? $clog2(TRAIL_N) : 1;
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int EW = (EMIT_DIV > 1) ? $clog2(EMIT_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TRAIL_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_EMIT, S_CLEAR} state_e;

  state_e                    state_q;
  logic [IW-1:0]             idx_q;
  logic [IW-1:0]             wr_ptr_q;
  logic [DW-1:0]             decay_cnt_q;
  logic [EW-1:0]             emit_cnt_q;
  logic                      busy_q;
  logic [TRAIL_N-1:0][9:0]   x_q;
  logic [TRAIL_N-1:0][8:0]   y_q;
  logic [TRAIL_N-1:0][3:0]   life_q;

  logic [9:0]    cur_x;
  logic [3:0]    cur_life;
  logic [9:0]    sweep_x_d;
  logic [3:0]    sweep_life_d;
  logic [9:0]    emit_sum;
  logic [8:0]    emit_y_d;
  logic [IW-1:0] wr_ptr_d;
  logic [DW-1:0] decay_cnt_d;
  logic [EW-1:0] emit_cnt_d;

  assign cur_x    = x_q[idx_q];
  assign cur_life = life_q[idx_q];

  // A particle that would drift past the left edge dies instead of wrapping.
  always_comb begin
    sweep_x_d    = cur_x;
    sweep_life_d = cur_life;
    if (cur_life != 4'd0) begin
      if (cur_x < 10'(DRIFT)) begin
        sweep_life_d = 4'd0;
      end else begin
        sweep_x_d = cur_x - 10'(DRIFT);
        if (decay_cnt_q == '0) sweep_life_d = cur_life - 4'd1;
      end
    end
  end

  assign emit_sum    = {1'b0, player_y} + 10'(PLAYER_SIZE / 2);
  assign emit_y_d    = (emit_sum > 10'd479) ? 9'd479 : emit_sum[8:0];
  assign wr_ptr_d    = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
  assign decay_cnt_d = (decay_cnt_q == DW'(DECAY_DIV - 1)) ? '0 : decay_cnt_q + 1'b1;
  assign emit_cnt_d  = (emit_cnt_q == EW'(EMIT_DIV - 1)) ? '0 : emit_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      decay_cnt_q <= '0;
      emit_cnt_q  <= '0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      life_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            idx_q <= '0;
            case (gamemode)
              2'b01, 2'b11: begin
                state_q <= S_SWEEP;
                busy_q  <= 1'b1;
              end
              2'b00: begin
                state_q <= S_CLEAR;
                busy_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_SWEEP: begin
          x_q[idx_q]    <= sweep_x_d;
          life_q[idx_q] <= sweep_life_d;
          if (idx_q == LAST_IDX) begin
            decay_cnt_q <= decay_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            // Mode is sampled here, so a late switch to game-over still suppresses emission.
            if (gamemode == 2'b01 && emit_cnt_q == '0) begin
              state_q <= S_EMIT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_EMIT: begin
          x_q[wr_ptr_q]    <= 10'(PLAYER_X - 2);
          y_q[wr_ptr_q]    <= emit_y_d;
          life_q[wr_ptr_q] <= 4'(LIFE_MAX);
          wr_ptr_q         <= wr_ptr_d;
          state_q          <= S_IDLE;
          busy_q           <= 1'b0;
        end
        S_CLEAR: begin
          x_q[idx_q]    <= '0;
          y_q[idx_q]    <= '0;
          life_q[idx_q] <= '0;
          if (idx_q == LAST_IDX) begin
            wr_ptr_q    <= '0;
            decay_cnt_q <= '0;
            emit_cnt_q  <= '0;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trail_x    = x_q;
  assign trail_y    = y_q;
  assign trail_life = life_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_trail_manager.sv
// Bench for trail_manager: a frame-level particle model pushes expected table
// contents and busy lengths to a scoreboard that is popped after each frame.
module tb_trail_manager;

  localparam int N  = 41;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstN [NI];
  logic                tick [NI];
  logic [1:0]          mode [NI];
  logic [8:0]          py   [NI];
  logic [N-1:0][9:0]   tx   [NI];
  logic [N-1:0][8:0]   ty   [NI];
  logic [N-1:0][3:0]   tl   [NI];
  logic                bsy  [NI];

  // Instance 0 uses defaults; 1 suppresses emission; 2 spawns near the left edge.
  trail_manager #(.EMIT_DIV(1)) dutA (
    .clk(clk), .rst_n(rstN[0]), .frame_tick(tick[0]), .gamemode(mode[0]), .player_y(py[0]),
    .trail_x(tx[0]), .trail_y(ty[0]), .trail_life(tl[0]), .busy(bsy[0]));
  trail_manager #(.EMIT_DIV(64)) dutB (
    .clk(clk), .rst_n(rstN[1]), .frame_tick(tick[1]), .gamemode(mode[1]), .player_y(py[1]),
    .trail_x(tx[1]), .trail_y(ty[1]), .trail_life(tl[1]), .busy(bsy[1]));
  trail_manager #(.EMIT_DIV(64), .PLAYER_X(20)) dutC (
    .clk(clk), .rst_n(rstN[2]), .frame_tick(tick[2]), .gamemode(mode[2]), .player_y(py[2]),
    .trail_x(tx[2]), .trail_y(ty[2]), .trail_life(tl[2]), .busy(bsy[2]));

  typedef struct {
    string tag;
    int    inst;
    int    kind;
    int    slot;
    int    value;
  } exp_t;

  exp_t sbq[$];
  int   nAssert = 0;
  int   nFail   = 0;
  int   busyLen [NI];

  int mx [NI][N];
  int my [NI][N];
  int ml [NI][N];
  int mwr [NI];
  int mdc [NI];
  int mec [NI];

  function automatic int emitDiv(int i);
    return (i == 0) ? 1 : 64;
  endfunction

  function automatic int playerX(int i);
    return (i == 2) ? 20 : 160;
  endfunction

  function automatic void pushExp(string tag, int inst, int kind, int slot, int value);
    exp_t e;
    e.tag = tag; e.inst = inst; e.kind = kind; e.slot = slot; e.value = value;
    sbq.push_back(e);
  endfunction

  function automatic void modelReset(int i);
    for (int s = 0; s < N; s++) begin
      mx[i][s] = 0; my[i][s] = 0; ml[i][s] = 0;
    end
    mwr[i] = 0; mdc[i] = 0; mec[i] = 0;
  endfunction

  // Returns expected busy length, or -1 when it is not checked.
  function automatic int modelFrame(int i, logic [1:0] m, logic [8:0] p);
    int yy;
    bit emitted;
    if (m == 2'b10) return 0;
    if (m == 2'b00) begin
      modelReset(i);
      return -1;
    end
    for (int s = 0; s < N; s++) begin
      if (ml[i][s] > 0) begin
        if (mx[i][s] < 4) ml[i][s] = 0;
        else begin
          mx[i][s] = mx[i][s] - 4;
          if (mdc[i] == 0) ml[i][s] = ml[i][s] - 1;
        end
      end
    end
    emitted = (m == 2'b01) && (mec[i] == 0);
    if (emitted) begin
      yy = int'(p) + 20;
      if (yy > 479) yy = 479;
      mx[i][mwr[i]] = playerX(i) - 2;
      my[i][mwr[i]] = yy;
      ml[i][mwr[i]] = 10;
      mwr[i] = (mwr[i] + 1) % N;
    end
    mdc[i] = (mdc[i] + 1) % 2;
    mec[i] = (mec[i] + 1) % emitDiv(i);
    return emitted ? 42 : 41;
  endfunction

  function automatic void pushTable(int i, string tag, bit full);
    for (int s = 0; s < N; s++) begin
      pushExp({tag, "_life"}, i, 2, s, ml[i][s]);
      if (full || ml[i][s] > 0) begin
        pushExp({tag, "_x"}, i, 0, s, mx[i][s]);
        pushExp({tag, "_y"}, i, 1, s, my[i][s]);
      end
    end
  endfunction

  function automatic int observe(int inst, int kind, int slot);
    case (kind)
      0:       return int'(tx[inst][slot]);
      1:       return int'(ty[inst][slot]);
      2:       return int'(tl[inst][slot]);
      3:       return busyLen[inst];
      default: return int'(bsy[inst]);
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    int   obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.inst, e.kind, e.slot);
      nAssert++;
      assert (obs === e.value) else begin
        nFail++;
        $error("[TB] FAIL %s inst%0d slot%0d: observed %0d expected %0d",
               e.tag, e.inst, e.slot, obs, e.value);
      end
    end
  endtask

  // One frame: pulse frame_tick, optionally poke a second tick or a reset, then score.
  task automatic applyStimulus(input int i, input logic [1:0] m, input logic [8:0] p,
                               input int extraTickAt, input int resetAt, input string tag);
    int expBusy;
    mode[i] = m;
    py[i]   = p;
    if (resetAt < 0) begin
      expBusy = modelFrame(i, m, p);
      if (expBusy >= 0) pushExp({tag, "_busyLen"}, i, 3, 0, expBusy);
      pushTable(i, tag, m == 2'b00);
    end else begin
      modelReset(i);
      pushTable(i, tag, 1'b1);
      pushExp({tag, "_busy"}, i, 4, 0, 0);
    end
    @(negedge clk);
    tick[i] = 1'b1;
    @(negedge clk);
    tick[i] = 1'b0;
    busyLen[i] = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bsy[i]) busyLen[i]++;
      tick[i] = (c == extraTickAt);
      if (c == resetAt) rstN[i] = 1'b0;
      @(negedge clk);
      if (c == resetAt) break;
    end
    tick[i] = 1'b0;
    checkOutput();
    rstN[i] = 1'b1;
  endtask

  initial begin
    logic [8:0] pv;
    for (int i = 0; i < NI; i++) begin
      rstN[i] = 1'b0; tick[i] = 1'b0; mode[i] = 2'b01; py[i] = '0; busyLen[i] = 0;
      modelReset(i);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      pushTable(i, "reset", 1'b1);
      pushExp("reset_busy", i, 4, 0, 0);
    end
    checkOutput();
    for (int i = 0; i < NI; i++) rstN[i] = 1'b1;
    @(negedge clk);

    applyStimulus(0, 2'b01, 9'd200, -1, -1, "firstEmit");
    for (int k = 1; k <= 41; k++) begin
      pv = (k == 20) ? 9'd459 : (k == 21) ? 9'd460 : (k == 22) ? 9'd511 : 9'((k * 13) % 440);
      applyStimulus(0, 2'b01, pv, -1, -1, "wrap");
    end
    for (int k = 0; k < 5; k++) applyStimulus(0, 2'b01, 9'(30 + k), -1, -1, "run5");
    for (int k = 0; k < 3; k++) applyStimulus(0, 2'b10, 9'd300, -1, -1, "pause");
    for (int k = 0; k < 4; k++) applyStimulus(0, 2'b11, 9'd300, -1, -1, "gameOver");
    applyStimulus(0, 2'b01, 9'd120, 10, -1, "tickBusy");
    applyStimulus(0, 2'b00, 9'd120, 10, -1, "clear");
    applyStimulus(0, 2'b01, 9'd77, -1, -1, "afterClear");
    applyStimulus(0, 2'b01, 9'd88, -1, 20, "resetMid");
    applyStimulus(0, 2'b01, 9'd99, -1, -1, "afterReset");

    applyStimulus(1, 2'b01, 9'd100, -1, -1, "decayEmit");
    applyStimulus(1, 2'b10, 9'd100, -1, -1, "decayPause");
    for (int k = 0; k < 24; k++) applyStimulus(1, 2'b01, 9'd100, -1, -1, "decay");

    for (int k = 0; k < 8; k++) applyStimulus(2, 2'b01, 9'd50, -1, -1, "driftKill");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
